// File: rtl/serial_to_parallel_8_if.sv
// Link-side signals of the serial-to-parallel front end: one serial bit in,
// the aligned byte and its qualifiers out.
interface serial_to_parallel_8_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_strobe,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_strobe,
        output active
    );
endinterface

// File: rtl/serial_to_parallel_8.sv
// Receive PHY front end: finds byte alignment on a serial stream via COMMA,
// locks after LOCK_COUNT aligned commas, then emits one byte per 8 clocks.
//
// state  | meaning
// SEARCH | sliding compare on every edge, looking for the first comma
// LOCK   | aligned, counting consecutive commas on byte boundaries
// ACTIVE | locked (sticky until reset), bytes delivered on each boundary
module serial_to_parallel_8 #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    serial_to_parallel_8_if.slave  link
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCK   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       sr;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [CNT_W-1:0] comma_cnt, comma_cnt_nxt;
    logic [7:0]       data_q, data_nxt;
    logic             valid_q, valid_nxt;
    logic             strobe_q, strobe_nxt;
    logic             active_q, active_nxt;
    logic [7:0]       nxt;
    logic             boundary;
    logic             is_comma;

    assign nxt      = {sr[6:0], link.data_in};
    assign boundary = (bit_cnt == 3'd7);
    assign is_comma = (nxt == COMMA);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            comma_cnt <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= nxt;
            bit_cnt   <= bit_cnt_nxt;
            comma_cnt <= comma_cnt_nxt;
            data_q    <= data_nxt;
            valid_q   <= valid_nxt;
            strobe_q  <= strobe_nxt;
            active_q  <= active_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt + 3'd1;
        comma_cnt_nxt = comma_cnt;
        data_nxt      = data_q;
        valid_nxt     = valid_q;
        strobe_nxt    = 1'b0;
        active_nxt    = active_q;

        unique case (state)
            SEARCH: begin
                bit_cnt_nxt = 3'd0;
                if (is_comma) begin
                    comma_cnt_nxt = CNT_W'(1);
                    state_nxt     = LOCK;
                end
            end
            LOCK: begin
                if (boundary) begin
                    if (is_comma) begin
                        if (comma_cnt != CNT_MAX)
                            comma_cnt_nxt = comma_cnt + CNT_W'(1);
                        // Entry edge into ACTIVE deliberately carries no strobe.
                        if (comma_cnt + CNT_W'(1) == CNT_LOCK) begin
                            state_nxt  = ACTIVE;
                            active_nxt = 1'b1;
                        end
                    end else begin
                        // Rejected byte is not re-scanned; search resumes next edge.
                        state_nxt     = SEARCH;
                        comma_cnt_nxt = '0;
                        bit_cnt_nxt   = 3'd0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    data_nxt   = nxt;
                    valid_nxt  = !is_comma;
                    strobe_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = SEARCH;
                bit_cnt_nxt = 3'd0;
            end
        endcase
    end

    assign link.data_out    = data_q;
    assign link.valid_out   = valid_q;
    assign link.byte_strobe = strobe_q;
    assign link.active      = active_q;

endmodule
